// File: rtl/morse_pkg.sv
// Shared types, timing constants and the A-Z Morse pattern table for the keyer.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    GAP,
    WORD
  } state_t;

  localparam int unsigned DOT_UNITS        = 1;
  localparam int unsigned DASH_UNITS       = 3;
  localparam int unsigned ELEM_GAP_UNITS   = 1;
  localparam int unsigned LETTER_GAP_UNITS = 3;
  localparam int unsigned WORD_UNITS       = 4;
  localparam int unsigned SPACE_CODE       = 26;

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned PAT_W   = 4;
  localparam int unsigned UNITS_W = 2;
  localparam int unsigned LETTERS = 26;

  // Entry = {len, pat}; pat is read MSB-first, 1 = dash, unused low bits are 0.
  localparam logic [LEN_W+PAT_W-1:0] MORSE_TABLE [LETTERS] = '{
    {3'd2, 4'b0100}, // A .-
    {3'd4, 4'b1000}, // B -...
    {3'd4, 4'b1010}, // C -.-.
    {3'd3, 4'b1000}, // D -..
    {3'd1, 4'b0000}, // E .
    {3'd4, 4'b0010}, // F ..-.
    {3'd3, 4'b1100}, // G --.
    {3'd4, 4'b0000}, // H ....
    {3'd2, 4'b0000}, // I ..
    {3'd4, 4'b0111}, // J .---
    {3'd3, 4'b1010}, // K -.-
    {3'd4, 4'b0100}, // L .-..
    {3'd2, 4'b1100}, // M --
    {3'd2, 4'b1000}, // N -.
    {3'd3, 4'b1110}, // O ---
    {3'd4, 4'b0110}, // P .--.
    {3'd4, 4'b1101}, // Q --.-
    {3'd3, 4'b0100}, // R .-.
    {3'd3, 4'b0000}, // S ...
    {3'd1, 4'b1000}, // T -
    {3'd3, 4'b0010}, // U ..-
    {3'd4, 4'b0001}, // V ...-
    {3'd3, 4'b0110}, // W .--
    {3'd4, 4'b1001}, // X -..-
    {3'd4, 4'b1011}, // Y -.--
    {3'd4, 4'b1100}  // Z --..
  };

endpackage

// File: rtl/morse_rom.sv
// Letter index to Morse pattern lookup; indices at or above SPACE_CODE are word spaces.
module morse_rom
  import morse_pkg::*;
(
  input  logic [IDX_W-1:0] letra,
  output logic [LEN_W-1:0] len,
  output logic [PAT_W-1:0] pat,
  output logic             is_space
);

  always_comb begin
    len      = '0;
    pat      = '0;
    is_space = 1'b0;
    if (letra >= IDX_W'(SPACE_CODE)) begin
      is_space = 1'b1;
    end else begin
      {len, pat} = MORSE_TABLE[letra];
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Converts one accepted letter index into Morse on/off keying with unit-accurate timing.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 12_500_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] letra,
  input  logic             valid,
  output logic             ready,
  output logic             key,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TIMER_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(UNIT_CYCLES - 1);

  localparam logic [UNITS_W-1:0] DOT_LOAD   = UNITS_W'(DOT_UNITS - 1);
  localparam logic [UNITS_W-1:0] DASH_LOAD  = UNITS_W'(DASH_UNITS - 1);
  localparam logic [UNITS_W-1:0] EGAP_LOAD  = UNITS_W'(ELEM_GAP_UNITS - 1);
  localparam logic [UNITS_W-1:0] LGAP_LOAD  = UNITS_W'(LETTER_GAP_UNITS - 1);
  localparam logic [UNITS_W-1:0] WORD_LOAD  = UNITS_W'(WORD_UNITS - 1);

  state_t               state, state_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [UNITS_W-1:0]   units, units_n;
  logic [PAT_W-1:0]     pat_q, pat_n;
  logic [LEN_W-1:0]     elems, elems_n;
  logic                 key_n, busy_n, done_n, ready_n;

  logic [LEN_W-1:0]     rom_len;
  logic [PAT_W-1:0]     rom_pat;
  logic                 rom_space;
  logic                 unit_end, phase_end;

  morse_rom u_rom (
    .letra    (letra),
    .len      (rom_len),
    .pat      (rom_pat),
    .is_space (rom_space)
  );

  assign unit_end  = (timer == '0);
  assign phase_end = unit_end && (units == '0);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_n = state;
    timer_n = timer;
    units_n = units;
    pat_n   = pat_q;
    elems_n = elems;

    if (state != IDLE) begin
      if (unit_end) begin
        timer_n = RELOAD;
        if (units != '0) units_n = units - UNITS_W'(1);
      end else begin
        timer_n = timer - TIMER_W'(1);
      end
    end

    unique case (state)
      IDLE: begin
        if (valid && ready) begin
          timer_n = RELOAD;
          pat_n   = rom_pat;
          elems_n = rom_len;
          if (rom_space) begin
            state_n = WORD;
            units_n = WORD_LOAD;
          end else begin
            state_n = MARK;
            units_n = rom_pat[PAT_W-1] ? DASH_LOAD : DOT_LOAD;
          end
        end
      end
      MARK: begin
        if (phase_end) begin
          if (elems > LEN_W'(1)) begin
            state_n = SPACE;
            units_n = EGAP_LOAD;
          end else begin
            state_n = GAP;
            units_n = LGAP_LOAD;
          end
        end
      end
      SPACE: begin
        // Next element's length comes from the bit about to shift into the MSB.
        if (phase_end) begin
          state_n = MARK;
          pat_n   = {pat_q[PAT_W-2:0], 1'b0};
          elems_n = elems - LEN_W'(1);
          units_n = pat_q[PAT_W-2] ? DASH_LOAD : DOT_LOAD;
        end
      end
      GAP, WORD: begin
        if (phase_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    key_n   = (state_n == MARK);
    busy_n  = (state_n != IDLE);
    ready_n = (state_n == IDLE);
    done_n  = (state != IDLE) && (state_n == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      timer <= '0;
      units <= '0;
      pat_q <= '0;
      elems <= '0;
      key   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ready <= 1'b1;
    end else begin
      state <= state_n;
      timer <= timer_n;
      units <= units_n;
      pat_q <= pat_n;
      elems <= elems_n;
      key   <= key_n;
      busy  <= busy_n;
      done  <= done_n;
      ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_morse_keyer.sv
// Scoreboard bench for morse_keyer: expected per-cycle {key,busy,done,ready} queued at stimulus time.
module tb_morse_keyer;

  localparam int unsigned UNIT = 4;

  logic       CLK;
  logic       RST;
  logic [4:0] letra;
  logic       valid;
  logic       ready;
  logic       key;
  logic       busy;
  logic       done;

  typedef struct {
    logic [3:0] v;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   build_cyc;

  morse_keyer #(.UNIT_CYCLES(UNIT)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .letra (letra),
    .valid (valid),
    .ready (ready),
    .key   (key),
    .busy  (busy),
    .done  (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pop one expectation per cycle, sampled mid-cycle.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check_eq(e.tag, {28'd0, key, busy, done, ready}, {28'd0, e.v});
    end
  end

  task automatic push_n(input int n, input logic k, input logic b, input logic d,
                        input logic r, input string name);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.v   = {k, b, d, r};
      e.tag = $sformatf("%s c%0d {key,busy,done,ready}", name, build_cyc);
      q.push_back(e);
      build_cyc++;
    end
  endtask

  // code: string of '.'/'-'; empty string means word space.
  task automatic send(input logic [4:0] idx, input string name, input string code);
    build_cyc = 0;
    if (q.size() == 0) push_n(1, 1'b0, 1'b0, 1'b0, 1'b1, name);
    else build_cyc = 1;
    if (code.len() == 0) begin
      push_n(4 * UNIT, 1'b0, 1'b1, 1'b0, 1'b0, name);
    end else begin
      for (int i = 0; i < code.len(); i++) begin
        push_n(((code[i] == "-") ? 3 : 1) * UNIT, 1'b1, 1'b1, 1'b0, 1'b0, name);
        if (i != code.len() - 1) push_n(UNIT, 1'b0, 1'b1, 1'b0, 1'b0, name);
      end
      push_n(3 * UNIT, 1'b0, 1'b1, 1'b0, 1'b0, name);
    end
    push_n(1, 1'b0, 1'b0, 1'b1, 1'b1, name);
    valid = 1'b1;
    letra = idx;
    @(posedge CLK); #1;
    valid = 1'b0;
  endtask

  task automatic wait_q(input int keep, input int budget);
    int n = 0;
    while (q.size() > keep && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    if (q.size() > keep) begin
      check_eq("wait_timeout queue_size", 32'(q.size()), 32'(keep));
      q.delete();
    end
  endtask

  initial begin
    RST   = 1'b1;
    valid = 1'b1;
    letra = 5'd4;
    repeat (3) @(posedge CLK);
    #1;
    RST   = 1'b0;
    valid = 1'b0;
    @(negedge CLK);
    check_eq("reset key",   32'(key),   32'd0);
    check_eq("reset busy",  32'(busy),  32'd0);
    check_eq("reset done",  32'(done),  32'd0);
    check_eq("reset ready", 32'(ready), 32'd1);
    @(posedge CLK); #1;
    build_cyc = 0;
    push_n(6, 1'b0, 1'b0, 1'b0, 1'b1, "post_reset_idle");
    wait_q(0, 50);

    send(5'd4, "E", ".");
    wait_q(0, 200);

    send(5'd0, "A", ".-");
    wait_q(0, 200);

    // T then S accepted in T's done cycle.
    send(5'd19, "T", "-");
    wait_q(1, 200);
    send(5'd18, "S", "...");
    wait_q(0, 300);

    // Word space with a valid pulse while busy that must be ignored.
    send(5'd31, "WSP", "");
    repeat (4) @(posedge CLK);
    #1;
    valid = 1'b1;
    letra = 5'd4;
    @(posedge CLK); #1;
    valid = 1'b0;
    wait_q(0, 200);
    build_cyc = 0;
    push_n(10, 1'b0, 1'b0, 1'b0, 1'b1, "after_wsp_idle");
    wait_q(0, 50);

    send(5'd25, "Z", "--..");
    wait_q(0, 300);

    // Q aborted by reset in cycle 10.
    send(5'd16, "Q", "--.-");
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    q.delete();
    build_cyc = 11;
    push_n(60, 1'b0, 1'b0, 1'b0, 1'b1, "Q_reset_idle");
    wait_q(0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
